// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl
//   Successive-approximation ADC controller. Drives a DAC trial code,
//   resolves one bit per cycle from the external comparator (MSB first),
//   latches the final code and then streams it out serially (MSB first).
//   Supports single conversions on a selected mux channel and a
//   continuous round-robin mode over all channels.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   clr          synchronous active-high reset
//   Start        begins a frame (only looked at in IDLE)
//   Continuous   repeat frames back to back, stepping through channels
//   ChanSel      channel for single mode, captured with Start
//   Compare      comparator: 1 when analog input >= B
//   B            DAC trial code
//   Chan         analog mux select, stable for a whole frame
//   LoadReg      one-cycle strobe while Result/ResultChan are loaded
//   Result       last converted code
//   ResultChan   channel that Result was taken from
//   DataMark     high while SerialOutput carries valid bits
//   SerialOutput serial copy of Result, MSB first
//   Busy         high whenever not IDLE
module sar_adc_ctrl #(
  parameter int N   = 8,
  parameter int CH  = 4,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           Start,
  input  logic           Continuous,
  input  logic [CHW-1:0] ChanSel,
  input  logic           Compare,
  output logic [N-1:0]   B,
  output logic [CHW-1:0] Chan,
  output logic           LoadReg,
  output logic [N-1:0]   Result,
  output logic [CHW-1:0] ResultChan,
  output logic           DataMark,
  output logic           SerialOutput,
  output logic           Busy
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD, SHIFT} state_t;

  localparam logic [N-1:0] FIRST_TRIAL = {1'b1, {(N-1){1'b0}}};

  state_t       state;
  // One-hot pointer: in CONV it marks the bit under test, in SHIFT it
  // tracks how many bits remain; the frame phase ends when bit 0 is set.
  logic [N-1:0] mask;
  // Remaining serial bits, MSB is the next bit to present.
  logic [N-1:0] shreg;

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      mask         <= '0;
      shreg        <= '0;
      B            <= '0;
      Chan         <= '0;
      LoadReg      <= 1'b0;
      Result       <= '0;
      ResultChan   <= '0;
      DataMark     <= 1'b0;
      SerialOutput <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= CONV;
            Busy  <= 1'b1;
            B     <= FIRST_TRIAL;
            mask  <= FIRST_TRIAL;
            // In continuous mode the round-robin position is kept.
            if (!Continuous) begin
              Chan <= (int'(ChanSel) < CH) ? ChanSel : '0;
            end
          end
        end

        CONV: begin
          // Clear the tested bit if the input is below the trial code,
          // then raise the next lower bit as the new trial.
          B    <= (Compare ? B : (B & ~mask)) | (mask >> 1);
          mask <= mask >> 1;
          if (mask[0]) begin
            state   <= LOAD;
            LoadReg <= 1'b1;
          end
        end

        LOAD: begin
          state        <= SHIFT;
          LoadReg      <= 1'b0;
          Result       <= B;
          ResultChan   <= Chan;
          DataMark     <= 1'b1;
          SerialOutput <= B[N-1];
          shreg        <= B << 1;
          mask         <= FIRST_TRIAL;
        end

        SHIFT: begin
          SerialOutput <= shreg[N-1];
          shreg        <= shreg << 1;
          mask         <= mask >> 1;
          if (mask[0]) begin
            DataMark     <= 1'b0;
            SerialOutput <= 1'b0;
            if (Continuous) begin
              state <= CONV;
              B     <= FIRST_TRIAL;
              mask  <= FIRST_TRIAL;
              Chan  <= (int'(Chan) == CH - 1) ? '0 : Chan + CHW'(1);
            end else begin
              state <= IDLE;
              B     <= '0;
              Busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          B     <= '0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: an 8-bit/4-channel instance and a
// 12-bit/3-channel instance, each with a behavioural comparator.
module tb_sar_adc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic       Start;
  logic       Continuous;
  logic [1:0] ChanSel;
  logic       Compare;
  logic [7:0] B;
  logic [1:0] Chan;
  logic       LoadReg;
  logic [7:0] Result;
  logic [1:0] ResultChan;
  logic       DataMark;
  logic       SerialOutput;
  logic       Busy;

  logic [7:0] analog [4];
  assign Compare = (analog[Chan] >= B);

  sar_adc_ctrl #(.N(8), .CH(4), .CHW(2)) dut (
    .clk(clk), .clr(clr), .Start(Start), .Continuous(Continuous),
    .ChanSel(ChanSel), .Compare(Compare), .B(B), .Chan(Chan),
    .LoadReg(LoadReg), .Result(Result), .ResultChan(ResultChan),
    .DataMark(DataMark), .SerialOutput(SerialOutput), .Busy(Busy)
  );

  logic        Start12;
  logic        Continuous12;
  logic [1:0]  ChanSel12;
  logic        Compare12;
  logic [11:0] B12;
  logic [1:0]  Chan12;
  logic        LoadReg12;
  logic [11:0] Result12;
  logic [1:0]  ResultChan12;
  logic        DataMark12;
  logic        SerialOutput12;
  logic        Busy12;

  assign Compare12 = (12'hABC >= B12);

  sar_adc_ctrl #(.N(12), .CH(3), .CHW(2)) dut12 (
    .clk(clk), .clr(clr), .Start(Start12), .Continuous(Continuous12),
    .ChanSel(ChanSel12), .Compare(Compare12), .B(B12), .Chan(Chan12),
    .LoadReg(LoadReg12), .Result(Result12), .ResultChan(ResultChan12),
    .DataMark(DataMark12), .SerialOutput(SerialOutput12), .Busy(Busy12)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] trials_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  logic [7:0] cont_vals [4] = '{8'h10, 8'h20, 8'h30, 8'h40};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_Chan"}, Chan, 0);
    chk({tag, "_Result"}, Result, 0);
    chk({tag, "_ResultChan"}, ResultChan, 0);
    chk({tag, "_LoadReg"}, LoadReg, 0);
    chk({tag, "_DataMark"}, DataMark, 0);
    chk({tag, "_Serial"}, SerialOutput, 0);
    chk({tag, "_Busy"}, Busy, 0);
  endtask

  // One single-mode frame on the 8-bit instance. pulse_at != 0 drives
  // Start during that cycle (it must be ignored).
  task automatic frame8(input logic [7:0] val, input logic [1:0] sel,
                        input logic [1:0] exp_ch, input bit chk_trials,
                        input int pulse_at);
    int lr = 0;
    int dm = 0;
    int extra = 0;
    for (int i = 0; i < 4; i++) analog[i] = val;
    ChanSel    = sel;
    Continuous = 1'b0;
    Start      = 1'b1;
    step();
    Start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (LoadReg) lr++;
      if (DataMark) dm++;
      if (c <= 8) begin
        if (chk_trials) chk("trial_B", B, trials_a5[c-1]);
        chk("busy_conv", Busy, 1);
        chk("chan_conv", Chan, exp_ch);
      end else if (c == 9) begin
        chk("loadreg", LoadReg, 1);
        chk("b_load", B, val);
      end else if (c <= 17) begin
        chk("serial_bit", SerialOutput, val[17-c]);
        chk("datamark", DataMark, 1);
        chk("chan_shift", Chan, exp_ch);
      end else begin
        chk("busy_idle", Busy, 0);
        chk("b_idle", B, 0);
        chk("datamark_idle", DataMark, 0);
        chk("result", Result, val);
        chk("result_chan", ResultChan, exp_ch);
      end
      Start = (c == pulse_at);
      step();
    end
    Start = 1'b0;
    chk("loadreg_count", lr, 1);
    chk("datamark_count", dm, 8);
    if (pulse_at != 0) begin
      for (int c = 0; c < 20; c++) begin
        if (LoadReg || Busy) extra++;
        step();
      end
      chk("start_in_shift_ignored", extra, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lp;
    int last;
    bit pend;
    int lr12;

    clr = 1'b1; Start = 1'b0; Continuous = 1'b0; ChanSel = '0;
    Start12 = 1'b0; Continuous12 = 1'b0; ChanSel12 = 2'd3;
    for (int i = 0; i < 4; i++) analog[i] = 8'h00;
    step(); step(); step();
    chk_reset_outputs("reset");
    clr = 1'b0;
    step();

    // Reference conversion plus channel select 2.
    frame8(8'hA5, 2'd2, 2'd2, 1'b1, 0);
    // Boundary codes.
    frame8(8'h00, 2'd1, 2'd1, 1'b0, 0);
    frame8(8'hFF, 2'd3, 2'd3, 1'b0, 0);
    // Start during SHIFT is ignored.
    frame8(8'h5A, 2'd0, 2'd0, 1'b0, 12);

    // clr in the 4th CONV cycle.
    for (int i = 0; i < 4; i++) analog[i] = 8'h77;
    ChanSel = 2'd1;
    Start   = 1'b1;
    step();
    Start = 1'b0;
    step(); step(); step();   // now in cycle 4
    clr = 1'b1;
    step();
    chk_reset_outputs("clr_midframe");
    clr = 1'b0;
    frame8(8'h3C, 2'd1, 2'd1, 1'b0, 0);

    // Continuous round-robin from channel 0.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) analog[i] = cont_vals[i];
    Continuous = 1'b1;
    ChanSel    = 2'd3;
    Start      = 1'b1;
    step();
    Start = 1'b0;
    lp = 0; last = 0; pend = 1'b0;
    for (int c = 1; c < 200; c++) begin
      if (pend) begin
        chk("cont_result", Result, cont_vals[(lp-1)%4]);
        chk("cont_result_chan", ResultChan, (lp-1)%4);
        pend = 1'b0;
      end
      if (LoadReg) begin
        if (lp > 0) chk("cont_loadreg_period", c - last, 17);
        last = c;
        lp++;
        pend = 1'b1;
        if (lp == 5) Continuous = 1'b0;
      end
      if (lp == 5 && !pend && !Busy) break;
      step();
    end
    chk("cont_frames", lp, 5);
    chk("cont_idle", Busy, 0);

    // 12-bit instance, out-of-range ChanSel maps to channel 0.
    ChanSel12 = 2'd3;
    Start12   = 1'b1;
    step();
    Start12 = 1'b0;
    lr12 = 0;
    for (int c = 1; c <= 25; c++) begin
      if (LoadReg12) lr12++;
      chk("n12_chan", Chan12, 0);
      step();
    end
    chk("n12_loadreg_count", lr12, 1);
    chk("n12_busy_idle", Busy12, 0);
    chk("n12_result", Result12, 12'hABC);
    chk("n12_result_chan", ResultChan12, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Parametrised successive-approximation ADC controller, the next generation of the fixed 8-bit `ADCCtrl` used in `rtl_top`. It drives the DAC trial code and samples the external comparator, one bit per cycle, MSB first. It then latches the converted code and streams it out serially, MSB first. Beyond the fixed controller it adds generic resolution, an analog-mux channel index, and a continuous round-robin mode. It sits behind the pad ring in the top level; B feeds the DAC and Result feeds downstream registers.

## Interface
Parameters:
- N, 8, conversion resolution in bits; N ≥ 2.
- CH, 4, number of analog mux channels; CH ≥ 1.
- CHW, 2, channel index width; must satisfy CHW ≥ max(1, clog2(CH)).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- clr  in  1  reset: synchronous, active-high.
- Start  in  1  starts a frame; sampled only in IDLE.
- Continuous  in  1  when 1, frames repeat back to back, round-robin over the channels.
- ChanSel  in  CHW  channel used in single mode; sampled together with Start.
- Compare  in  1  comparator result: 1 means analog input ≥ B. Must be settled before each CONV-ending edge.
- B  out  N  DAC trial code.
- Chan  out  CHW  analog mux select; constant for a whole frame.
- LoadReg  out  1  one-cycle strobe; Result and ResultChan update on this same edge.
- Result  out  N  last converted code.
- ResultChan  out  CHW  channel that Result came from.
- DataMark  out  1  high while SerialOutput carries valid bits.
- SerialOutput  out  1  serial copy of Result, MSB first.
- Busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE → CONV (N cycles) → LOAD (1 cycle) → SHIFT (N cycles) → CONV (next frame) or IDLE.
- IDLE, on Start=1:
  - Go to CONV.
  - If Continuous=0, Chan ← ChanSel. If Continuous=1, Chan keeps its current value.
- CONV, cycle k (k = 0..N-1), testing bit i = N-1-k:
  - B = bits already decided above i, bit i = 1, all bits below i = 0.
  - On the edge ending the cycle: bit i ← Compare.
- LOAD:
  - B holds the final code.
  - LoadReg=1.
  - Result ← final code, ResultChan ← Chan, both on the edge ending LOAD.
- SHIFT, cycle j (j = 0..N-1):
  - DataMark=1, SerialOutput = Result[N-1-j].
  - B holds the final code.
- At the end of SHIFT:
  - If Continuous=1 (sampled on the last SHIFT edge): Chan ← (Chan == CH-1) ? 0 : Chan+1, then go to CONV with B re-initialised to the first trial code.
  - Otherwise go to IDLE.
- IDLE outputs: B=0, DataMark=0, SerialOutput=0, LoadReg=0. Chan, Result and ResultChan hold their values.
- Start outside IDLE is ignored.
- Deasserting Continuous mid-frame: the current frame completes, then the block returns to IDLE.
- ChanSel ≥ CH in single mode: Chan ← 0.

## Timing
- Reset values (on any clk edge with clr=1): state IDLE; B=0, Chan=0, Result=0, ResultChan=0, LoadReg=0, DataMark=0, SerialOutput=0, Busy=0.
- clr has priority over all other inputs. When clr is asserted mid-frame, the frame is abandoned and Result is cleared.
- Start sampled at edge E0:
  - CONV occupies cycles 1..N.
  - LOAD is cycle N+1; Result is valid from edge N+1.
  - SHIFT occupies cycles N+2..2N+1.
  - Busy falls after edge 2N+1.
- Frame period in continuous mode: 2N+1 cycles, with no idle gap between frames.
- Busy rises on the edge that samples Start.
- Compare is sampled only on CONV-ending edges; its value at any other edge is don't-care.

## Test plan
- N=8, single mode, comparator model Compare = (0xA5 ≥ B), Start at cycle 0:
  - B trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - LoadReg pulses in cycle 9; Result=0xA5.
  - SerialOutput = 1,0,1,0,0,1,0,1 while DataMark=1 in cycles 10..17.
  - Busy=0 from cycle 18.
- Boundary codes: analog input 0x00 → Result=0x00; analog input 0xFF → Result=0xFF. Each with exactly one LoadReg pulse and eight DataMark cycles.
- Continuous=1, CH=4, ChanSel ignored, analog value per channel {0x10, 0x20, 0x30, 0x40}:
  - ResultChan sequence 0,1,2,3,0.
  - Result sequence 0x10, 0x20, 0x30, 0x40, 0x10.
  - LoadReg pulses exactly 17 cycles apart.
- clr asserted in the 4th CONV cycle → next cycle: all outputs at reset values, Busy=0. A fresh Start then converts correctly.
- Start pulsed during SHIFT with Continuous=0 → ignored; the block returns to IDLE after the frame and no second LoadReg occurs.
- Single mode with ChanSel=2 → Chan=2 throughout the frame and ResultChan=2. Repeat with N=12, CH=3, ChanSel=3 → Chan=0, and 12-bit conversion of 0xABC produces Result=0xABC.
